// File: rtl/led_pwm_capture_pkg.sv
// Shared LED demo definitions: channel count, channel indices and the capture FSM states.
// Used by the PWM generator, the capture block and the demo top level.
package led_pkg;

  localparam int NUM_LED       = 8;
  localparam int CNT_W_DEFAULT = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int CH_A = 0;
  localparam int CH_B = 1;
  localparam int CH_C = 2;
  localparam int CH_D = 3;
  localparam int CH_E = 4;
  localparam int CH_F = 5;
  localparam int CH_G = 6;
  localparam int CH_H = 7;

endpackage

// File: rtl/led_pwm_capture_if.sv
// PWM capture bundle: PWM lines and frame marker in, recovered brightness bytes out.
// CNT_W must match the CNT_W of the attached led_pwm_capture.
interface led_pwm_capture_if
  import led_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
);

  logic [NUM_LED-1:0] pwm_in;
  logic               fclk;
  logic [CNT_W-1:0]   data_a;
  logic [CNT_W-1:0]   data_b;
  logic [CNT_W-1:0]   data_c;
  logic [CNT_W-1:0]   data_d;
  logic [CNT_W-1:0]   data_e;
  logic [CNT_W-1:0]   data_f;
  logic [CNT_W-1:0]   data_g;
  logic [CNT_W-1:0]   data_h;
  logic               data_valid;
  logic               frame_err;

  modport master (
    output pwm_in, fclk,
    input  data_a, data_b, data_c, data_d, data_e, data_f, data_g, data_h,
    input  data_valid, frame_err
  );

  modport slave (
    input  pwm_in, fclk,
    output data_a, data_b, data_c, data_d, data_e, data_f, data_g, data_h,
    output data_valid, frame_err
  );

endinterface

// File: rtl/led_pwm_capture_counter.sv
// Per-channel saturating high-time counter. clr_load restarts the count at pwm_bit,
// en accumulates pwm_bit; the count sticks at all-ones instead of wrapping.
module pwm_chan_counter
  import led_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             en,
  input  logic             clr_load,
  input  logic             pwm_bit,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      count <= '0;
    end else if (clr_load) begin
      count <= CNT_W'(pwm_bit);
    end else if (en && pwm_bit && (count != CNT_MAX)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/led_pwm_capture.sv
// Recovers 8 PWM brightness bytes by counting high cycles between fclk frame markers,
// with frame-lock tracking: a frame longer than TIMEOUT cycles drops back to IDLE.
module led_pwm_capture
  import led_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEFAULT,
  parameter int TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 nreset,
  led_pwm_capture_if.slave     lb
);

  localparam int               PER_W     = $clog2(TIMEOUT + 1);
  localparam logic [PER_W-1:0] PER_MAX   = '1;
  localparam logic [PER_W-1:0] TIMEOUT_V = PER_W'(TIMEOUT);

  state_t           state_q, state_d;
  logic [PER_W-1:0] period_cnt;
  logic             cnt_en;
  logic             cnt_clr_load;
  logic             bit_pass;
  logic             close_frame;
  logic             timeout;
  logic [CNT_W-1:0] cnt    [NUM_LED];
  logic [CNT_W-1:0] data_q [NUM_LED];
  logic             valid_q;
  logic             err_q;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    cnt_en       = 1'b0;
    cnt_clr_load = 1'b1;
    bit_pass     = 1'b0;
    close_frame  = 1'b0;
    timeout      = 1'b0;
    case (state_q)
      IDLE: begin
        if (lb.fclk) begin
          state_d  = RUN;
          bit_pass = 1'b1;
        end
      end
      RUN: begin
        // fclk takes priority over timeout: a frame of exactly TIMEOUT cycles is legal.
        if (lb.fclk) begin
          close_frame = 1'b1;
          bit_pass    = 1'b1;
        end else if (period_cnt >= TIMEOUT_V) begin
          timeout = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_clr_load = 1'b0;
          cnt_en       = 1'b1;
          bit_pass     = 1'b1;
        end
      end
    endcase
  end

  // Period counter follows the channel counters: loads 1 on fclk, clears when idle/lost.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      period_cnt <= '0;
    end else if (cnt_clr_load) begin
      period_cnt <= PER_W'(bit_pass);
    end else if (period_cnt != PER_MAX) begin
      period_cnt <= period_cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_LED; i++) begin : g_chan
    pwm_chan_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk      (clk),
      .nreset   (nreset),
      .en       (cnt_en),
      .clr_load (cnt_clr_load),
      .pwm_bit  (lb.pwm_in[i] & bit_pass),
      .count    (cnt[i])
    );
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < NUM_LED; i++) data_q[i] <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= close_frame;
      if (close_frame) begin
        for (int i = 0; i < NUM_LED; i++) data_q[i] <= cnt[i];
      end
      if (timeout)          err_q <= 1'b1;
      else if (close_frame) err_q <= 1'b0;
    end
  end

  assign lb.data_a     = data_q[CH_A];
  assign lb.data_b     = data_q[CH_B];
  assign lb.data_c     = data_q[CH_C];
  assign lb.data_d     = data_q[CH_D];
  assign lb.data_e     = data_q[CH_E];
  assign lb.data_f     = data_q[CH_F];
  assign lb.data_g     = data_q[CH_G];
  assign lb.data_h     = data_q[CH_H];
  assign lb.data_valid = valid_q;
  assign lb.frame_err  = err_q;

endmodule

// File: tb/tb_led_pwm_capture.sv
// Self-checking bench for led_pwm_capture: a frame-level reference model queues expected
// reports, and a negedge monitor pops and compares them whenever data_valid is seen.
module tb_led_pwm_capture;
  import led_pkg::*;

  localparam int CNT_W   = 8;
  localparam int TIMEOUT = 1024;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef logic [NUM_LED-1:0][CNT_W-1:0] data_vec_t;
  typedef struct {
    int        due;
    data_vec_t vals;
  } frame_t;

  logic clk    = 1'b0;
  logic nreset = 1'b1;

  led_pwm_capture_if #(.CNT_W(CNT_W)) lb ();

  led_pwm_capture #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk    (clk),
    .nreset (nreset),
    .lb     (lb)
  );

  always #5 clk = ~clk;

  frame_t             exp_q[$];
  logic [NUM_LED-1:0] cur[$];
  bit                 locked  = 1'b0;
  bit                 err_exp = 1'b0;
  data_vec_t          held    = '0;
  int                 cyc     = 0;
  int                 checks  = 0;
  int                 errors  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic data_vec_t dut_data();
    return {lb.data_h, lb.data_g, lb.data_f, lb.data_e,
            lb.data_d, lb.data_c, lb.data_b, lb.data_a};
  endfunction

  // Frame-level reference: a frame is the list of PWM samples since the last fclk.
  function automatic void model_step(input logic [NUM_LED-1:0] p, input logic f);
    frame_t fr;
    if (f) begin
      if (locked) begin
        for (int ch = 0; ch < NUM_LED; ch++) begin
          int n = 0;
          foreach (cur[i]) n += int'(cur[i][ch]);
          fr.vals[ch] = CNT_W'((n > CNT_MAX) ? CNT_MAX : n);
        end
        fr.due = cyc;
        exp_q.push_back(fr);
        err_exp = 1'b0;
      end
      locked = 1'b1;
      cur.delete();
      cur.push_back(p);
    end else if (locked) begin
      if (cur.size() >= TIMEOUT) begin
        locked  = 1'b0;
        err_exp = 1'b1;
        cur.delete();
      end else begin
        cur.push_back(p);
      end
    end
  endfunction

  task automatic step(input logic [NUM_LED-1:0] p, input logic f);
    lb.pwm_in = p;
    lb.fclk   = f;
    @(posedge clk);
    cyc++;
    if (nreset) model_step(p, f);
    #1;
  endtask

  // duty[ch] < 0 gives random PWM on that channel; otherwise high for the first duty[ch] cycles.
  task automatic run_frame(input int len, input int duty[NUM_LED]);
    for (int i = 0; i < len; i++) begin
      logic [NUM_LED-1:0] p;
      for (int ch = 0; ch < NUM_LED; ch++)
        p[ch] = (duty[ch] < 0) ? 1'($urandom) : (i < duty[ch]);
      step(p, i == 0);
    end
  endtask

  task automatic run_random_frame(input int len);
    int duty[NUM_LED];
    for (int ch = 0; ch < NUM_LED; ch++) duty[ch] = -1;
    run_frame(len, duty);
  endtask

  always @(negedge clk) begin
    frame_t fr;
    if (lb.data_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_valid", 64'(lb.data_valid), 64'd0);
      end else begin
        fr = exp_q.pop_front();
        check("valid_cycle", 64'(cyc), 64'(fr.due));
        for (int ch = 0; ch < NUM_LED; ch++)
          check($sformatf("data[%0d]", ch), 64'(dut_data()[ch]), 64'(fr.vals[ch]));
        held = fr.vals;
      end
    end else begin
      if (exp_q.size() > 0 && cyc >= exp_q[0].due) begin
        check("missing_valid", 64'(lb.data_valid), 64'd1);
        fr   = exp_q.pop_front();
        held = fr.vals;
      end
      check("data_hold", 64'(dut_data()), 64'(held));
    end
    check("frame_err", 64'(lb.frame_err), 64'(err_exp));
  end

  initial begin
    int duty[NUM_LED];
    lb.pwm_in = '0;
    lb.fclk   = 1'b0;
    #1 nreset = 1'b0;
    #1;
    check("reset_data",  64'(dut_data()), 64'd0);
    check("reset_valid", 64'(lb.data_valid), 64'd0);
    check("reset_err",   64'(lb.frame_err), 64'd0);
    repeat (2) @(posedge clk);
    #1 nreset = 1'b1;
    repeat (3) step('0, 1'b0);

    // a = 64 high cycles, b never high, h always high (256 saturates to 255), rest random.
    duty = '{64, 0, -1, -1, -1, -1, -1, 300};
    repeat (3) run_frame(256, duty);
    check("t1_data_a", 64'(lb.data_a), 64'd64);
    check("t1_data_b", 64'(lb.data_b), 64'd0);
    check("t1_data_h", 64'(lb.data_h), 64'd255);

    duty = '{1, 2, 4, 8, 16, 32, 128, 200};
    repeat (3) run_frame(256, duty);
    check("t2_data_g", 64'(lb.data_g), 64'd128);

    // Lose lock: one long frame with no closing fclk, then relock.
    repeat (2) run_random_frame(256);
    run_random_frame(TIMEOUT + 80);
    check("t3_err_set", 64'(lb.frame_err), 64'd1);
    repeat (2) run_random_frame(200);
    check("t3_err_clr", 64'(lb.frame_err), 64'd0);

    // Frame of exactly TIMEOUT cycles: fclk coincides with the timeout condition.
    run_random_frame(TIMEOUT);
    run_random_frame(TIMEOUT);
    run_random_frame(40);
    check("t4_no_err", 64'(lb.frame_err), 64'd0);

    // Back-to-back fclk: one-cycle frame.
    step(8'hFF, 1'b1);
    step(8'hFF, 1'b1);
    repeat (3) step(8'hFF, 1'b0);
    check("t5_data_a", 64'(lb.data_a), 64'd1);
    run_random_frame(30);

    for (int k = 0; k < 20; k++) run_random_frame(int'($urandom_range(1, 300)));

    // Asynchronous reset mid-frame.
    run_random_frame(50);
    run_random_frame(200);
    step(8'hFF, 1'b1);
    repeat (100) step(8'hFF, 1'b0);
    #2 nreset = 1'b0;
    locked  = 1'b0;
    err_exp = 1'b0;
    cur.delete();
    exp_q.delete();
    held = '0;
    #1;
    check("t6_rst_data",  64'(dut_data()), 64'd0);
    check("t6_rst_valid", 64'(lb.data_valid), 64'd0);
    check("t6_rst_err",   64'(lb.frame_err), 64'd0);
    repeat (2) step(8'hFF, 1'b1);
    nreset = 1'b1;
    repeat (3) run_random_frame(60);
    step(8'h5A, 1'b1);
    repeat (4) step('0, 1'b0);

    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_pwm_capture.md
Name: led_pwm_capture

Overview:
Receive-side counterpart of the LED PWM generator. Measures the high-time of 8 PWM lines over each frame delimited by the generator's frame pulse `fclk`, and recovers the 8 brightness bytes. Sits in the LED demo as a loopback/self-check block. Its outputs can be compared against the bytes driven into the generator.

Parameters:
- CNT_W, 8, width of each per-channel duty counter and data output; counters saturate at 2^CNT_W-1.
- TIMEOUT, 1024, clocks without an `fclk` pulse before the frame is declared lost; must be >= 2.

Ports:
- clk  input  1  system clock; all inputs synchronous to it.
- nreset  input  1  reset; asynchronous, active-low.
- pwm_in  input  8  PWM lines; bit 0 = channel a ... bit 7 = channel h.
- fclk  input  1  frame marker; one-cycle high pulse on the first cycle of each PWM frame.
- data_a..data_h  output  CNT_W each  last completed frame's high-cycle count per channel.
- data_valid  output  1  one-cycle pulse when data_a..data_h update.
- frame_err  output  1  high while frame lock is lost.

Behaviour:
- Interface: one clock `clk`; reset `nreset` is asynchronous, active-low.
- Reset values: all data_x = 0, data_valid = 0, frame_err = 0, all counters = 0, state = IDLE.
- Frame definition: from the `fclk` cycle (inclusive) to the next `fclk` cycle (exclusive).
- States:
  - IDLE: waiting for first `fclk`; counters held at 0; data_x held.
  - RUN: counting.
- IDLE -> RUN: on `fclk`=1.
  - That cycle loads cnt_x <= pwm_in[x] and period_cnt <= 1.
  - No data_valid is produced.
  - The first complete frame is therefore reported at the second `fclk`.
- In RUN, cycle with `fclk`=0:
  - cnt_x <= sat(cnt_x + pwm_in[x]), saturating at 2^CNT_W-1, no wrap.
  - period_cnt increments.
- In RUN, cycle with `fclk`=1:
  - data_x <= cnt_x (value accumulated up to the previous cycle).
  - data_valid <= 1 for exactly one cycle.
  - cnt_x <= pwm_in[x] (this cycle belongs to the new frame).
  - period_cnt <= 1.
  - frame_err <= 0.
- Latency: data_x and data_valid become visible the cycle after the closing `fclk`.
- Timeout (in RUN, `fclk`=0, period_cnt reaches TIMEOUT):
  - go to IDLE, frame_err <= 1, counters cleared.
  - data_x keep their last values; no data_valid.
- `fclk` on the same cycle as the timeout condition: `fclk` wins; normal frame close, no error.
- frame_err stays 1 through IDLE. It clears only at the next frame close in RUN, i.e. the first valid frame after relock.
- `fclk` on consecutive cycles (1-cycle frame): each one closes a frame; data_x = 0 or 1.
- period_cnt width: clog2(TIMEOUT+1); saturates, never wraps.
- Reset mid-frame: immediate return to reset values; the partial frame is discarded.
- Channels are fully independent; no cross-channel ordering.

Decomposition:
- Shared package `led_pkg`:
  - NUM_LED = 8.
  - default CNT_W = 8.
  - state encoding constants IDLE/RUN.
  - channel index constants a..h = 0..7, shared with the generator and the top level.
- One sub-module, `pwm_chan_counter`, instantiated 8 times.
  - Inputs: clk, nreset, en, clr_load, bit.
  - Output: saturating count.
- The top holds the FSM, period counter, timeout and output registers.

Test Plan:
- Reset then pulse `fclk` every 256 cycles; pwm_in[0] high 64 cycles/frame, [1] always low, [7] always high. Required: first data_valid at the 2nd pulse + 1 cycle; data_a = 64, data_b = 0, data_h = 255 (saturated from 256).
- Drive duties 1, 2, 4, 8, 16, 32, 128, 200 on a..h with period 256 across 3 frames. Required: exactly 3 data_valid pulses, each exactly 1 cycle wide, with identical values each time.
- Stop `fclk` after 2 frames, TIMEOUT = 1024. Required: frame_err rises exactly 1024 cycles after the last pulse; data_x unchanged; no data_valid. Resume pulses: first data_valid only at the 2nd new pulse; frame_err = 0 from that cycle on.
- Assert `fclk` on the same cycle period_cnt reaches TIMEOUT (period = TIMEOUT). Required: frame_err stays 0 and data_valid pulses.
- `fclk` high on 2 consecutive cycles with pwm_in = 8'hFF. Required: two data_valid pulses; the second reports data_x = 1.
- Assert nreset mid-frame with counts around 100. Required: all outputs 0 immediately (asynchronous); no data_valid until two `fclk` pulses after release.
